fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, one outstanding imem read, redirect from execute.
// Latency: request in the FETCH cycle; instruction presented the cycle after imem_rvalid.
// Backpressure: stall_IF freezes a fetched instruction in HOLD; no new request until it is consumed.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   stall_IF                  decode not accepting (only acts while an instruction is held)
//   PCSrc_EX, PCTarget_EX     taken branch/jump redirect and its target
//   imem_req, imem_addr       one-cycle instruction read request, word aligned
//   imem_rvalid, imem_rdata   read response
//   instr_IF, PC_IF, PCPlus4_IF, instr_valid_IF   towards the fetch/decode register
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF,
    input  logic        PCSrc_EX,
    input  logic [31:0] PCTarget_EX,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_IF,
    output logic [31:0] PC_IF,
    output logic [31:0] PCPlus4_IF,
    output logic        instr_valid_IF
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // issue the read for pc
        WAIT  = 2'd1,   // read outstanding, response wanted
        HOLD  = 2'd2,   // instruction buffered, waiting for decode to take it
        DROP  = 2'd3    // read outstanding but squashed by a redirect
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        vld_q, vld_d;

    logic [31:0] tgt_aligned;
    logic [31:0] pc_plus4;

    // Redirect targets are forced to a word boundary so pc[1:0] stays 00.
    assign tgt_aligned = PCTarget_EX & 32'hFFFF_FFFC;
    // 32-bit add wraps naturally: 0xFFFFFFFC + 4 = 0.
    assign pc_plus4    = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0000_0000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        vld_d   = vld_q;

        case (state_q)
            FETCH: begin
                // The request goes out this cycle regardless; a redirect
                // now means its response must be thrown away.
                if (PCSrc_EX) begin
                    pc_d    = tgt_aligned;
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (PCSrc_EX) begin
                    pc_d    = tgt_aligned;
                    state_d = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    buf_d   = imem_rdata;
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                // Redirect wins over stall: the held instruction is on the
                // wrong path and is discarded.
                if (PCSrc_EX) begin
                    pc_d    = tgt_aligned;
                    vld_d   = 1'b0;
                    state_d = FETCH;
                end else if (!stall_IF) begin
                    pc_d    = pc_plus4;
                    vld_d   = 1'b0;
                    state_d = FETCH;
                end
            end

            DROP: begin
                if (PCSrc_EX) begin
                    pc_d = tgt_aligned;
                end
                // The squashed response retires the only outstanding read, so
                // leave even if a new redirect lands in the same cycle;
                // otherwise we would wait for a response that never comes.
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Gated with rst so no request is seen while reset is held.
    assign imem_req       = (state_q == FETCH) && !rst;
    assign imem_addr      = pc_q;
    assign instr_IF       = vld_q ? buf_q : NOP_INSTR;
    assign PC_IF          = pc_q;
    assign PCPlus4_IF     = pc_plus4;
    assign instr_valid_IF = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall_IF = 1'b0;
    logic        PCSrc_EX = 1'b0;
    logic [31:0] PCTarget_EX = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_IF, PC_IF, PCPlus4_IF;
    logic        instr_valid_IF;

    // Second instance exercising the wrap-around reset PC.
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2 = 1'b0;
    logic [31:0] imem_rdata2;
    logic [31:0] instr2, pc2, pc42;
    logic        vld2;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall_IF(stall_IF), .PCSrc_EX(PCSrc_EX),
        .PCTarget_EX(PCTarget_EX), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_IF(instr_IF),
        .PC_IF(PC_IF), .PCPlus4_IF(PCPlus4_IF), .instr_valid_IF(instr_valid_IF)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .stall_IF(stall_IF), .PCSrc_EX(PCSrc_EX),
        .PCTarget_EX(PCTarget_EX), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .instr_IF(instr2),
        .PC_IF(pc2), .PCPlus4_IF(pc42), .instr_valid_IF(vld2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents, a pure function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h8) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    // Program-order view: cur_pc is the address the fetch stream must deliver
    // next. A redirect replaces it, a consumed instruction advances it by 4.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        last_e;
    logic [31:0] cur_pc = 32'h0;

    bit          rand_en   = 1'b0;
    logic        dir_stall = 1'b0;
    logic        dir_redir = 1'b0;
    logic [31:0] dir_tgt   = 32'h0;

    // Driver: new inputs each negedge (+1), model updated for the coming edge.
    always @(negedge clk) begin
        #1;
        if (rand_en) begin
            stall_IF    = ($urandom_range(0, 99) < 30);
            PCSrc_EX    = ($urandom_range(0, 99) < 8);
            PCTarget_EX = $urandom();
        end else begin
            stall_IF    = dir_stall;
            PCSrc_EX    = dir_redir;
            PCTarget_EX = dir_tgt;
        end
        if (rst) begin
            exp_q.delete();
            cur_pc = 32'h0;
            exp_q.push_back('{32'h0, mem_f(32'h0)});
        end else if (PCSrc_EX) begin
            cur_pc = PCTarget_EX & 32'hFFFF_FFFC;
            // An undelivered expectation is superseded; a delivered (held)
            // one is squashed, so either way the target comes next.
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            exp_q.push_back('{cur_pc, mem_f(cur_pc)});
        end else if (instr_valid_IF && !stall_IF) begin
            cur_pc = cur_pc + 32'd4;
            exp_q.push_back('{cur_pc, mem_f(cur_pc)});
        end
    end

    // Memory responder for dut: latency fixed or random 1..3.
    int          lat_mode = 1;
    bit          r_pend = 1'b0;
    int          r_cnt = 0;
    logic [31:0] r_addr = 32'h0;
    always @(negedge clk) begin
        if (rst) begin
            // Stale response from an abandoned read lands during reset.
            imem_rvalid = r_pend;
            imem_rdata  = 32'hBAD0_BAD0;
            r_pend      = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (r_pend) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_f(r_addr);
                    r_pend      = 1'b0;
                end
            end
            if (imem_req) begin
                check("one_outstanding", 32'(r_pend), 32'd0);
                r_pend = 1'b1;
                r_addr = imem_addr;
                r_cnt  = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
            end
        end
    end

    // Latency-1 responder for dut2.
    bit p2 = 1'b0;
    assign imem_rdata2 = 32'h0010_0093;
    always @(negedge clk) begin
        if (rst) begin
            imem_rvalid2 = 1'b0;
            p2 = 1'b0;
        end else begin
            imem_rvalid2 = p2;
            p2 = imem_req2;
        end
    end

    // Monitor: pops an expectation whenever a new instruction appears.
    bit prev_v = 1'b0;
    int idle_cyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v   = 1'b0;
            idle_cyc = 0;
        end else begin
            check("pc_track", PC_IF, cur_pc);
            check("pcplus4", PCPlus4_IF, cur_pc + 32'd4);
            if (imem_req) check("req_addr", imem_addr, cur_pc);
            if (!instr_valid_IF) begin
                check("nop_when_invalid", instr_IF, NOP);
            end else if (!prev_v) begin
                idle_cyc = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_instr: got pc %h, expected no instruction", PC_IF);
                end else begin
                    last_e = exp_q.pop_front();
                    check("deliv_pc", PC_IF, last_e.pc);
                    check("deliv_instr", instr_IF, last_e.ins);
                end
            end else begin
                check("held_pc", PC_IF, last_e.pc);
                check("held_instr", instr_IF, last_e.ins);
            end
            prev_v = instr_valid_IF;
            idle_cyc++;
            if (idle_cyc > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL progress_watchdog: got no instruction in 200 cycles, expected one");
                idle_cyc = 0;
            end
        end
    end

    // Apply inputs for the next cycle and move to its observation point.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        dir_stall = s;
        dir_redir = r;
        dir_tgt   = t;
        @(negedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_vld", 32'(instr_valid_IF), 32'd0);
        check("rst_instr", instr_IF, NOP);
        check("rst_pc", PC_IF, 32'h0);
        check("rst_pc4", PCPlus4_IF, 32'h4);
        check("rst2_pc4_wrap", pc42, 32'h0);
        check("rst2_req", 32'(imem_req2), 32'd0);

        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #2;                                   // cycle 0: FETCH
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_addr2", imem_addr2, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);              // cycle 1: WAIT
        check("c1_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'h0);              // cycle 2: HOLD, consumed at end
        check("c2_instr", instr_IF, 32'h0050_0093);
        check("c2_pc", PC_IF, 32'h0);
        check("c2_pc4", PCPlus4_IF, 32'h4);
        check("c2_vld", 32'(instr_valid_IF), 32'd1);
        check("c2_pc2", pc2, 32'hFFFF_FFFC);
        check("c2_pc42", pc42, 32'h0);
        step(1'b0, 1'b0, 32'h0);              // cycle 3: FETCH pc+4
        check("c3_req", 32'(imem_req), 32'd1);
        check("c3_addr", imem_addr, 32'h4);
        check("c3_addr2_wrap", imem_addr2, 32'h0);
        step(1'b0, 1'b0, 32'h0);              // cycle 4: WAIT
        step(1'b1, 1'b0, 32'h0);              // cycle 5: HOLD, stalled
        check("st_vld", 32'(instr_valid_IF), 32'd1);
        check("st_pc", PC_IF, 32'h4);
        check("st_instr", instr_IF, mem_f(32'h4));
        for (int k = 0; k < 3; k++) begin     // cycles 6,7 stalled, 8 released
            step((k < 2) ? 1'b1 : 1'b0, 1'b0, 32'h0);
            check("st_hold_vld", 32'(instr_valid_IF), 32'd1);
            check("st_hold_pc", PC_IF, 32'h4);
            check("st_hold_pc4", PCPlus4_IF, 32'h8);
            check("st_hold_instr", instr_IF, mem_f(32'h4));
            check("st_hold_req", 32'(imem_req), 32'd0);
        end
        lat_mode = 3;
        step(1'b0, 1'b0, 32'h0);              // cycle 9: FETCH 0x8
        check("c9_req", 32'(imem_req), 32'd1);
        check("c9_addr", imem_addr, 32'h8);
        lat_mode = 1;
        step(1'b0, 1'b1, 32'h103);            // cycle 10: WAIT + redirect
        check("rd_c10_vld", 32'(instr_valid_IF), 32'd0);
        step(1'b0, 1'b0, 32'h0);              // cycle 11: DROP
        check("rd_c11_vld", 32'(instr_valid_IF), 32'd0);
        check("rd_c11_pc", PC_IF, 32'h100);
        check("rd_c11_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'h0);              // cycle 12: DROP, 0xDEADBEEF arrives
        check("rd_c12_vld", 32'(instr_valid_IF), 32'd0);
        step(1'b0, 1'b0, 32'h0);              // cycle 13: FETCH target
        check("rd_c13_vld", 32'(instr_valid_IF), 32'd0);
        check("rd_c13_instr", instr_IF, NOP);
        check("rd_c13_req", 32'(imem_req), 32'd1);
        check("rd_c13_addr", imem_addr, 32'h100);
        step(1'b0, 1'b1, 32'h200);            // cycle 14: WAIT, redirect with rvalid
        step(1'b0, 1'b0, 32'h0);              // cycle 15: FETCH target
        check("same_c15_vld", 32'(instr_valid_IF), 32'd0);
        check("same_c15_req", 32'(imem_req), 32'd1);
        check("same_c15_addr", imem_addr, 32'h200);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);              // cycle 17: HOLD
        check("same_c17_vld", 32'(instr_valid_IF), 32'd1);
        check("same_c17_instr", instr_IF, mem_f(32'h200));

        lat_mode = 0;
        rand_en  = 1'b1;
        repeat (3000) @(negedge clk);

        // Reset in the middle of an outstanding read.
        rand_en  = 1'b0;
        lat_mode = 3;
        step(1'b0, 1'b0, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (imem_req) got = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        check("r37_found_fetch", 32'(got), 32'd1);
        step(1'b0, 1'b0, 32'h0);              // WAIT
        #3;
        rst = 1'b1;
        #1;
        check("r37_vld", 32'(instr_valid_IF), 32'd0);
        check("r37_instr", instr_IF, NOP);
        check("r37_pc", PC_IF, 32'h0);
        check("r37_pc4", PCPlus4_IF, 32'h4);
        check("r37_req", 32'(imem_req), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        lat_mode = 1;
        @(negedge clk);
        #2;
        check("r37_first_req", 32'(imem_req), 32'd1);
        check("r37_first_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("r37_first_vld", 32'(instr_valid_IF), 32'd1);
        check("r37_first_instr", instr_IF, 32'h0050_0093);

        lat_mode = 0;
        rand_en  = 1'b1;
        repeat (500) @(negedge clk);
        rand_en  = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
